// File: rtl/tlc_pkg.sv
// Shared lamp encodings and phase enumeration for the
// multiphase traffic-light sequencer.
package tlc_pkg;

    localparam logic [1:0] LT_RED    = 2'b00;
    localparam logic [1:0] LT_GREEN  = 2'b01;
    localparam logic [1:0] LT_YELLOW = 2'b10;

    typedef enum logic [1:0] {
        PH_GREEN   = 2'd0,
        PH_YELLOW  = 2'd1,
        PH_ALL_RED = 2'd2
    } phase_t;

endpackage

// File: rtl/tlc_rr_pick.sv
// Round-robin first-set search: scans req starting one past
// start, wrapping, and returns the first hit.
module tlc_rr_pick #(
    parameter int N = 4,
    parameter int W = $clog2(N)
) (
    input  logic [N-1:0] req,
    input  logic [W-1:0] start,
    output logic [W-1:0] idx,
    output logic         found
);

    int j;

    always_comb begin
        idx   = '0;
        found = 1'b0;
        j     = 0;
        // start itself is examined last so an idle approach
        // can still be chosen when it is the only one asking
        for (int i = 1; i <= N; i++) begin
            j = (int'(start) + i) % N;
            if (!found && req[j]) begin
                found = 1'b1;
                idx   = W'(j);
            end
        end
    end

endmodule

// File: rtl/tlc_multiphase.sv
// Demand-actuated round-robin traffic-light sequencer with
// min/max green, yellow, all-red clearance and preemption.
module tlc_multiphase
    import tlc_pkg::*;
#(
    parameter int NUM_DIR     = 4,
    parameter int TIMER_W     = 8,
    parameter int GREEN_MIN   = 10,
    parameter int GREEN_MAX   = 30,
    parameter int YELLOW_TIME = 3,
    parameter int ALLRED_TIME = 2,
    parameter int DW          = $clog2(NUM_DIR)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NUM_DIR-1:0]   demand,
    input  logic                 emerg_req,
    input  logic [DW-1:0]        emerg_dir,
    output logic [2*NUM_DIR-1:0] lights,
    output logic [DW-1:0]        active_dir,
    output logic [1:0]           phase,
    output logic [NUM_DIR-1:0]   served
);

    localparam logic [TIMER_W-1:0] YT    = TIMER_W'(YELLOW_TIME - 1);
    localparam logic [TIMER_W-1:0] AT    = TIMER_W'(ALLRED_TIME - 1);
    localparam logic [TIMER_W-1:0] GMIN1 = TIMER_W'(GREEN_MIN - 1);
    localparam logic [TIMER_W-1:0] GMAX1 = TIMER_W'(GREEN_MAX - 1);

    phase_t               phase_q, phase_n;
    logic [DW-1:0]        dir_q, dir_n;
    logic [DW-1:0]        nxt_q, nxt_n;
    logic [TIMER_W-1:0]   timer_q, timer_n;
    logic [TIMER_W-1:0]   gcnt_q, gcnt_n;
    logic [NUM_DIR-1:0]   served_q, served_n;

    logic [NUM_DIR-1:0]   other_dem;
    logic                 own_dem;
    logic                 go_exit;
    logic [DW-1:0]        pick_idx;
    logic                 pick_found;

    tlc_rr_pick #(
        .N (NUM_DIR),
        .W (DW)
    ) u_pick (
        .req   (demand),
        .start (dir_q),
        .idx   (pick_idx),
        .found (pick_found)
    );

    assign other_dem = demand & ~(NUM_DIR'(1) << dir_q);
    assign own_dem   = demand[dir_q];

    always_comb begin
        go_exit = 1'b0;
        if (emerg_req) begin
            go_exit = (emerg_dir != dir_q);
        end else if (other_dem != '0) begin
            go_exit = (!own_dem && gcnt_q >= GMIN1) ||
                      (gcnt_q == GMAX1);
        end
    end

    always_comb begin
        phase_n  = phase_q;
        dir_n    = dir_q;
        nxt_n    = nxt_q;
        timer_n  = timer_q;
        gcnt_n   = gcnt_q;
        served_n = '0;
        unique case (phase_q)
            PH_GREEN: begin
                if (gcnt_q != GMAX1) gcnt_n = gcnt_q + 1'b1;
                if (go_exit) begin
                    phase_n = PH_YELLOW;
                    timer_n = YT;
                    nxt_n   = pick_found ? pick_idx : dir_q;
                end
            end
            PH_YELLOW: begin
                if (timer_q == '0) begin
                    phase_n = PH_ALL_RED;
                    timer_n = AT;
                end else begin
                    timer_n = timer_q - 1'b1;
                end
            end
            PH_ALL_RED: begin
                if (timer_q == '0) begin
                    phase_n  = PH_GREEN;
                    dir_n    = emerg_req ? emerg_dir : nxt_q;
                    gcnt_n   = '0;
                    served_n = NUM_DIR'(1) << dir_n;
                end else begin
                    timer_n = timer_q - 1'b1;
                end
            end
            default: phase_n = PH_GREEN;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            phase_q  <= PH_GREEN;
            dir_q    <= '0;
            nxt_q    <= '0;
            timer_q  <= '0;
            gcnt_q   <= '0;
            served_q <= '0;
        end else begin
            phase_q  <= phase_n;
            dir_q    <= dir_n;
            nxt_q    <= nxt_n;
            timer_q  <= timer_n;
            gcnt_q   <= gcnt_n;
            served_q <= served_n;
        end
    end

    always_comb begin
        lights = '0;
        unique case (phase_q)
            PH_GREEN:  lights[2*int'(dir_q) +: 2] = LT_GREEN;
            PH_YELLOW: lights[2*int'(dir_q) +: 2] = LT_YELLOW;
            default:   lights = '0;
        endcase
    end

    assign active_dir = dir_q;
    assign phase      = phase_q;
    assign served     = served_q;

endmodule

// File: tb/tb_tlc_multiphase.sv
// Directed self-checking bench for tlc_multiphase with the
// default 4-approach parameter set.
module tb_tlc_multiphase;

    logic       clk;
    logic       rst;
    logic [3:0] demand;
    logic       emerg_req;
    logic [1:0] emerg_dir;
    logic [7:0] lights;
    logic [1:0] active_dir;
    logic [1:0] phase;
    logic [3:0] served;

    int tests;
    int fails;

    tlc_multiphase dut (
        .clk        (clk),
        .rst        (rst),
        .demand     (demand),
        .emerg_req  (emerg_req),
        .emerg_dir  (emerg_dir),
        .lights     (lights),
        .active_dir (active_dir),
        .phase      (phase),
        .served     (served)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic adv(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Leaves the bench 1 time unit after edge 0 with rst low.
    task automatic do_reset(input logic [3:0] dem);
        rst       = 1'b1;
        demand    = dem;
        emerg_req = 1'b0;
        emerg_dir = 2'd0;
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic chk_state(input string tag,
                             input logic [1:0] ph,
                             input logic [1:0] dir,
                             input logic [7:0] lt);
        chk({tag, ".phase"},  32'(phase),      32'(ph));
        chk({tag, ".dir"},    32'(active_dir), 32'(dir));
        chk({tag, ".lights"}, 32'(lights),     32'(lt));
    endtask

    logic [3:0] served_or;

    initial begin
        tests     = 0;
        fails     = 0;
        rst       = 1'b1;
        demand    = 4'b0000;
        emerg_req = 1'b0;
        emerg_dir = 2'd0;
        #2;
        chk_state("rst0", 2'd0, 2'd0, 8'b0000_0001);
        chk("rst0.served", 32'(served), 32'd0);

        // idle: approach 0 rests green with no demand
        do_reset(4'b0000);
        served_or = '0;
        for (int i = 0; i < 40; i++) begin
            adv(1);
            served_or |= served;
        end
        chk("idle.served", 32'(served_or), 32'd0);
        chk_state("idle", 2'd0, 2'd0, 8'b0000_0001);

        // single demand on approach 2, min green path
        do_reset(4'b0100);
        adv(9);
        chk_state("d2.g9", 2'd0, 2'd0, 8'b0000_0001);
        adv(1);
        chk_state("d2.y10", 2'd1, 2'd0, 8'b0000_0010);
        adv(2);
        chk_state("d2.y12", 2'd1, 2'd0, 8'b0000_0010);
        adv(1);
        chk_state("d2.r13", 2'd2, 2'd0, 8'b0000_0000);
        adv(1);
        chk_state("d2.r14", 2'd2, 2'd0, 8'b0000_0000);
        adv(1);
        chk_state("d2.g15", 2'd0, 2'd2, 8'b0001_0000);
        chk("d2.served15", 32'(served), 32'b0100);
        adv(1);
        chk("d2.served16", 32'(served), 32'd0);

        // constant 1011: max green rotation 0,1,3,0
        do_reset(4'b1011);
        adv(29);
        chk_state("rr.g29", 2'd0, 2'd0, 8'b0000_0001);
        adv(1);
        chk_state("rr.y30", 2'd1, 2'd0, 8'b0000_0010);
        adv(5);
        chk_state("rr.g35", 2'd0, 2'd1, 8'b0000_0100);
        chk("rr.served35", 32'(served), 32'b0010);
        adv(29);
        chk_state("rr.g64", 2'd0, 2'd1, 8'b0000_0100);
        adv(1);
        chk_state("rr.y65", 2'd1, 2'd1, 8'b0000_1000);
        adv(5);
        chk_state("rr.g70", 2'd0, 2'd3, 8'b0100_0000);
        chk("rr.served70", 32'(served), 32'b1000);
        adv(30);
        chk_state("rr.y100", 2'd1, 2'd3, 8'b1000_0000);
        adv(5);
        chk_state("rr.g105", 2'd0, 2'd0, 8'b0000_0001);
        chk("rr.served105", 32'(served), 32'b0001);

        // preemption from approach 1 green at g_cnt=2 to approach 3
        do_reset(4'b0010);
        adv(15);
        chk_state("em.g15", 2'd0, 2'd1, 8'b0000_0100);
        adv(2);
        demand    = 4'b0111;
        emerg_req = 1'b1;
        emerg_dir = 2'd3;
        adv(1);
        chk_state("em.y18", 2'd1, 2'd1, 8'b0000_1000);
        adv(2);
        chk_state("em.y20", 2'd1, 2'd1, 8'b0000_1000);
        adv(1);
        chk_state("em.r21", 2'd2, 2'd1, 8'b0000_0000);
        adv(2);
        chk_state("em.g23", 2'd0, 2'd3, 8'b0100_0000);
        chk("em.served23", 32'(served), 32'b1000);
        adv(40);
        chk_state("em.hold63", 2'd0, 2'd3, 8'b0100_0000);
        emerg_req = 1'b0;
        adv(1);
        chk_state("em.rel64", 2'd1, 2'd3, 8'b1000_0000);
        adv(5);
        chk_state("em.g69", 2'd0, 2'd0, 8'b0000_0001);

        // preemption arrives mid-yellow, next_dir=1 overridden to 2
        do_reset(4'b0010);
        adv(10);
        chk_state("my.y10", 2'd1, 2'd0, 8'b0000_0010);
        adv(1);
        emerg_req = 1'b1;
        emerg_dir = 2'd2;
        adv(1);
        chk_state("my.y12", 2'd1, 2'd0, 8'b0000_0010);
        adv(1);
        chk_state("my.r13", 2'd2, 2'd0, 8'b0000_0000);
        adv(1);
        chk_state("my.r14", 2'd2, 2'd0, 8'b0000_0000);
        adv(1);
        chk_state("my.g15", 2'd0, 2'd2, 8'b0001_0000);
        chk("my.served15", 32'(served), 32'b0100);
        emerg_req = 1'b0;

        // async reset mid-yellow on approach 2
        adv(10);
        chk_state("ar.y25", 2'd1, 2'd2, 8'b0010_0000);
        #2;
        rst = 1'b1;
        #1;
        chk_state("ar.rst", 2'd0, 2'd0, 8'b0000_0001);
        chk("ar.served", 32'(served), 32'd0);
        adv(2);
        rst = 1'b0;

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
